// File: rtl/matrix_stream_loader.sv
// Collects a row-major byte stream into one NxN (N=2..5) matrix on a flat 5x5 bus.
// Optional LOADER_CLEAR_EN adds a synchronous clr input that drops any matrix in progress.
module matrix_stream_loader #(
    parameter int DIM_MAX = 5,
    parameter int ELEM_W  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
`ifdef LOADER_CLEAR_EN
    input  logic                              clr,
`endif
    input  logic [2:0]                        size,
    input  logic                              in_valid,
    input  logic [ELEM_W-1:0]                 in_data,
    output logic                              in_ready,
    output logic                              mat_valid,
    output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] mat_flat,
    input  logic                              mat_ready,
    output logic [4:0]                        count,
    output logic                              size_err,
    output logic [1:0]                        fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and data is ignored while ready is low.

    localparam int FLAT_W = DIM_MAX * DIM_MAX * ELEM_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t     state, next_state;
    logic       started;
    logic [2:0] n;
    logic [2:0] row, col;
    logic [4:0] nn;
    logic [4:0] idx;
    logic       size_ok;
    logic [2:0] n_new;
    logic       last_elem;
    logic       take_in, take_out;
    logic       clear;

`ifdef LOADER_CLEAR_EN
    assign clear = clr;
`else
    assign clear = 1'b0;
`endif

    assign nn        = {2'b00, n} * {2'b00, n};
    assign idx       = {2'b00, row} * 5'(DIM_MAX) + {2'b00, col};
    assign size_ok   = (size >= 3'd2) && (size <= 3'd5);
    assign n_new     = size_ok ? size : 3'(DIM_MAX);
    assign last_elem = (count + 5'd1) == nn;
    assign fsm_state = state;

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        mat_valid  = 1'b0;
        take_in    = 1'b0;
        take_out   = 1'b0;
        case (state)
            IDLE: begin
                // started keeps in_ready low until the first edge after reset release
                in_ready = started;
                take_in  = in_valid && started;
                if (take_in) next_state = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                take_in  = in_valid;
                if (take_in && last_elem) next_state = FULL;
            end
            FULL: begin
                mat_valid = 1'b1;
                take_out  = mat_ready;
                if (take_out) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (clear) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            started  <= 1'b0;
            n        <= 3'(DIM_MAX);
            row      <= 3'd0;
            col      <= 3'd0;
            count    <= 5'd0;
            size_err <= 1'b0;
            mat_flat <= '0;
        end else begin
            started <= 1'b1;
            state   <= next_state;
            if (clear) begin
                row      <= 3'd0;
                col      <= 3'd0;
                count    <= 5'd0;
                size_err <= 1'b0;
                mat_flat <= '0;
            end else if (state == IDLE && take_in) begin
                n        <= n_new;
                size_err <= !size_ok;
                mat_flat <= {{(FLAT_W-ELEM_W){1'b0}}, in_data};
                count    <= 5'd1;
                row      <= 3'd0;
                col      <= 3'd1;
            end else if (state == LOAD && take_in) begin
                mat_flat[idx*ELEM_W +: ELEM_W] <= in_data;
                count <= count + 5'd1;
                // park row/col at zero on the last element so they stay within n-1
                if (last_elem) begin
                    row <= 3'd0;
                    col <= 3'd0;
                end else if (col == n - 3'd1) begin
                    col <= 3'd0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end else if (take_out) begin
                row   <= 3'd0;
                col   <= 3'd0;
                count <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader; clr scenarios compile in with LOADER_CLEAR_EN.
module tb_matrix_stream_loader;

    localparam int W = 200;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic [2:0]   size;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         mat_valid;
    logic [W-1:0] mat_flat;
    logic         mat_ready;
    logic [4:0]   count;
    logic         size_err;
    logic [1:0]   fsm_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]   elems[25];
    logic [W-1:0] exp_q[$];

    matrix_stream_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef LOADER_CLEAR_EN
        .clr       (clr),
`endif
        .size      (size),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mat_valid (mat_valid),
        .mat_flat  (mat_flat),
        .mat_ready (mat_ready),
        .count     (count),
        .size_err  (size_err),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference: element k of an n x n matrix is (r,c) = (k/n, k%n) at flat slot r*5+c.
    function automatic logic [W-1:0] model_matrix(input int n);
        logic [W-1:0] m;
        m = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                m[(r*5+c)*8 +: 8] = elems[r*n+c];
        return m;
    endfunction

    function automatic int clamp_n(input logic [2:0] s);
        return (s < 2 || s > 5) ? 5 : int'(s);
    endfunction

    task automatic fill_random(input int num);
        for (int k = 0; k < num; k++) elems[k] = 8'($urandom_range(255, 0));
    endtask

    // Drives elems[first..last-1]; optional random stalls and random size noise after element 0.
    task automatic load_elems(input int first, input int last, input logic [2:0] sz,
                              input int stall_max, input bit wobble);
        for (int i = first; i < last; i++) begin
            int st;
            int guard;
            st = (stall_max > 0) ? $urandom_range(stall_max, 0) : 0;
            if (st > 0) begin
                in_valid = 1'b0;
                repeat (st) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = elems[i];
            size     = (wobble && i > 0) ? 3'($urandom_range(7, 0)) : sz;
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL load_timeout: element %0d not accepted, in_ready=%0b required 1", i, in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        int guard;
        guard = 0;
        while (!mat_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        mat_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mat_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; size = 3'd5; in_valid = 1'b0; in_data = 8'd0; mat_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, mat_valid, count, size_err} !== 8'd0 || mat_flat !== '0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%0b mat_valid=%0b count=%0d size_err=%0b flat_zero=%0b required all 0",
                     in_ready, mat_valid, count, size_err, mat_flat == '0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_full_5x5();
        logic [W-1:0] exp;
        for (int k = 0; k < 25; k++) elems[k] = 8'(k + 1);
        exp = model_matrix(5);
        load_elems(0, 24, 3'd5, 0, 0);
        checks++;
        if (mat_valid !== 1'b0 || count !== 5'd24) begin
            errors++;
            $display("FAIL n5_before_last: mat_valid=%0b count=%0d required 0 and 24", mat_valid, count);
        end
        load_elems(24, 25, 3'd5, 0, 0);
        checks++;
        if (mat_valid !== 1'b1 || count !== 5'd25 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL n5_done: mat_valid=%0b count=%0d in_ready=%0b required 1 25 0", mat_valid, count, in_ready);
        end
        checks++;
        if (mat_flat[7:0] !== 8'd1 || mat_flat[199:192] !== 8'd25 || mat_flat !== exp) begin
            errors++;
            $display("FAIL n5_flat: got %h required %h", mat_flat, exp);
        end
        consume();
        checks++;
        if (mat_valid !== 1'b0 || count !== 5'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL n5_release: mat_valid=%0b count=%0d in_ready=%0b required 0 0 1", mat_valid, count, in_ready);
        end
    endtask

    task automatic test_n2();
        logic [W-1:0] exp;
        elems[0] = 8'h81; elems[1] = 8'h02; elems[2] = 8'h7F; elems[3] = 8'hFF;
        exp = model_matrix(2);
        load_elems(0, 4, 3'd2, 0, 0);
        checks++;
        if (mat_valid !== 1'b1 || count !== 5'd4 || size_err !== 1'b0) begin
            errors++;
            $display("FAIL n2_done: mat_valid=%0b count=%0d size_err=%0b required 1 4 0", mat_valid, count, size_err);
        end
        checks++;
        if (mat_flat[15:0] !== 16'h0281 || mat_flat[55:40] !== 16'hFF7F || mat_flat !== exp) begin
            errors++;
            $display("FAIL n2_flat: got %h required %h", mat_flat, exp);
        end
        consume();
    endtask

    task automatic test_size_err();
        logic [W-1:0] exp;
        fill_random(25);
        exp = model_matrix(5);
        load_elems(0, 1, 3'd7, 0, 0);
        checks++;
        if (size_err !== 1'b1 || count !== 5'd1) begin
            errors++;
            $display("FAIL size7_first: size_err=%0b count=%0d required 1 1", size_err, count);
        end
        load_elems(1, 9, 3'd7, 1, 0);
        checks++;
        if (mat_valid !== 1'b0 || count !== 5'd9) begin
            errors++;
            $display("FAIL size7_clamped: mat_valid=%0b count=%0d required 0 9", mat_valid, count);
        end
        load_elems(9, 25, 3'd7, 1, 0);
        checks++;
        if (mat_valid !== 1'b1 || count !== 5'd25 || mat_flat !== exp || size_err !== 1'b1) begin
            errors++;
            $display("FAIL size7_done: mat_valid=%0b count=%0d size_err=%0b flat %h required 1 25 1 %h",
                     mat_valid, count, size_err, mat_flat, exp);
        end
        consume();
        fill_random(9);
        exp = model_matrix(3);
        load_elems(0, 1, 3'd3, 0, 0);
        checks++;
        if (size_err !== 1'b0) begin
            errors++;
            $display("FAIL size3_err_clear: size_err=%0b required 0", size_err);
        end
        load_elems(1, 9, 3'd3, 0, 0);
        checks++;
        if (mat_valid !== 1'b1 || mat_flat !== exp) begin
            errors++;
            $display("FAIL size3_flat: mat_valid=%0b got %h required %h", mat_valid, mat_flat, exp);
        end
        consume();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp;
        int bad;
        fill_random(9);
        exp = model_matrix(3);
        load_elems(0, 9, 3'd3, 0, 0);
        in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            in_data = 8'($urandom_range(255, 0));
            @(posedge clk);
            @(negedge clk);
            if (in_ready !== 1'b0 || mat_valid !== 1'b1 || mat_flat !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_full: %0d of 10 cycles with in_ready=1, mat_valid=0 or changed flat, required 0", bad);
        end
        in_valid  = 1'b0;
        mat_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mat_ready = 1'b0;
        checks++;
        if (mat_valid !== 1'b0 || in_ready !== 1'b1 || fsm_state !== 2'd0 || mat_flat !== exp) begin
            errors++;
            $display("FAIL hold_release: mat_valid=%0b in_ready=%0b state=%0d flat_kept=%0b required 0 1 0 1",
                     mat_valid, in_ready, fsm_state, mat_flat == exp);
        end
    endtask

    task automatic test_reset_midload();
        logic [W-1:0] exp;
        fill_random(16);
        load_elems(0, 7, 3'd4, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mat_valid, count, size_err} !== 8'd0 || mat_flat !== '0) begin
            errors++;
            $display("FAIL midload_reset: in_ready=%0b mat_valid=%0b count=%0d size_err=%0b flat_zero=%0b required all 0",
                     in_ready, mat_valid, count, size_err, mat_flat == '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random(16);
        exp = model_matrix(4);
        load_elems(0, 16, 3'd4, 0, 0);
        checks++;
        if (mat_valid !== 1'b1 || count !== 5'd16 || mat_flat !== exp) begin
            errors++;
            $display("FAIL after_reset_load: mat_valid=%0b count=%0d flat %h required 1 16 %h",
                     mat_valid, count, mat_flat, exp);
        end
        consume();
    endtask

    task automatic test_random();
        for (int m = 0; m < 8; m++) begin
            logic [2:0]   sz;
            int           n;
            int           dly;
            logic [W-1:0] exp;
            sz = 3'($urandom_range(7, 0));
            n  = clamp_n(sz);
            fill_random(n * n);
            exp_q.push_back(model_matrix(n));
            load_elems(0, n * n, sz, 2, 1);
            exp = exp_q.pop_front();
            checks++;
            if (mat_valid !== 1'b1 || count !== 5'(n * n) || mat_flat !== exp
                || size_err !== (sz < 3'd2 || sz > 3'd5)) begin
                errors++;
                $display("FAIL random_%0d: size=%0d mat_valid=%0b count=%0d size_err=%0b flat %h required n=%0d flat %h",
                         m, sz, mat_valid, count, size_err, mat_flat, n, exp);
            end
            dly = $urandom_range(3, 0);
            repeat (dly) @(negedge clk);
            consume();
            checks++;
            if (mat_valid !== 1'b0 || count !== 5'd0) begin
                errors++;
                $display("FAIL random_release_%0d: mat_valid=%0b count=%0d required 0 0", m, mat_valid, count);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream[12];
        int         t_valid[$];
        int         idx;
        int         got;
        logic       accept;
        for (int k = 0; k < 12; k++) stream[k] = 8'($urandom_range(255, 0));
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 4; k++) elems[k] = stream[m*4+k];
            exp_q.push_back(model_matrix(2));
        end
        idx = 0;
        got = 0;
        size = 3'd2; in_valid = 1'b1; in_data = stream[0]; mat_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            accept = in_ready && in_valid;
            if (mat_valid) begin
                t_valid.push_back(cyc);
                if (exp_q.size() > 0) begin
                    logic [W-1:0] exp;
                    exp = exp_q.pop_front();
                    checks++;
                    if (mat_flat !== exp) begin
                        errors++;
                        $display("FAIL b2b_flat_%0d: got %h required %h", got, mat_flat, exp);
                    end
                end
                got++;
            end
            @(posedge clk);
            @(negedge clk);
            if (accept) begin
                idx++;
                if (idx >= 12) in_valid = 1'b0;
                else in_data = stream[idx];
            end
        end
        mat_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (t_valid.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: %0d matrices seen, required 3", t_valid.size());
        end else begin
            checks++;
            if (t_valid[1] - t_valid[0] != 5 || t_valid[2] - t_valid[1] != 5) begin
                errors++;
                $display("FAIL b2b_period: spacing %0d and %0d cycles, required 5 and 5",
                         t_valid[1] - t_valid[0], t_valid[2] - t_valid[1]);
            end
        end
        exp_q.delete();
    endtask

`ifdef LOADER_CLEAR_EN
    task automatic test_clr();
        fill_random(4);
        load_elems(0, 4, 3'd2, 0, 0);
        clr = 1'b1;
        mat_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        mat_ready = 1'b0;
        checks++;
        if (mat_valid !== 1'b0 || count !== 5'd0 || mat_flat !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_full: mat_valid=%0b count=%0d flat_zero=%0b in_ready=%0b required 0 0 1 1",
                     mat_valid, count, mat_flat == '0, in_ready);
        end
        fill_random(4);
        load_elems(0, 3, 3'd6, 0, 0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        clr      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== 5'd0 || size_err !== 1'b0 || mat_flat !== '0 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL clr_load: count=%0d size_err=%0b flat_zero=%0b state=%0d required 0 0 1 0",
                     count, size_err, mat_flat == '0, fsm_state);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_5x5();
        test_n2();
        test_size_err();
        test_backpressure();
        test_reset_midload();
        test_random();
        test_back_to_back();
`ifdef LOADER_CLEAR_EN
        test_clr();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
